// File: rtl/msdap_mem_loader_if.sv
// msdap_mem_loader_if: S2P input, ALU handshake and memory write ports of the MSDAP loader
interface msdap_mem_loader_if;
   logic        in_valid;
   logic [15:0] in_word;
   logic        alu_busy;
   logic        rj_we;
   logic [3:0]  rj_waddr;
   logic [7:0]  rj_wdata;
   logic        coeff_we;
   logic [8:0]  coeff_waddr;
   logic [15:0] coeff_wdata;
   logic        data_we;
   logic [7:0]  data_waddr;
   logic [15:0] data_wdata;
   logic [7:0]  current_data_addr;
   logic        alu_start;
   logic        run;
   logic        sleep;
   logic        overrun;
   logic        drop_err;
   modport slave (
      input  in_valid, in_word, alu_busy,
      output rj_we, rj_waddr, rj_wdata, coeff_we, coeff_waddr, coeff_wdata,
             data_we, data_waddr, data_wdata, current_data_addr, alu_start,
             run, sleep, overrun, drop_err
   );
   modport master (
      output in_valid, in_word, alu_busy,
      input  rj_we, rj_waddr, rj_wdata, coeff_we, coeff_waddr, coeff_wdata,
             data_we, data_waddr, data_wdata, current_data_addr, alu_start,
             run, sleep, overrun, drop_err
   );
endinterface

// File: rtl/msdap_mem_loader.sv
// msdap_mem_loader: fills Rj, coefficient and circular data memories and starts the ALU per sample
module msdap_mem_loader #(
   parameter int ZERO_LIMIT = 800
) (
   input logic               clk,
   input logic               clear_n,
   msdap_mem_loader_if.slave bus
);
   localparam logic [9:0] LIM = 10'(ZERO_LIMIT);
   typedef enum logic [1:0] {S_CLEAR, S_RJ, S_COEFF, S_RUN} state_t;
   state_t      r_state, w_next;
   logic [8:0]  r_cnt;
   logic [7:0]  r_wptr, r_cda;
   logic [9:0]  r_zcnt, w_zcnt;
   logic        w_clr, w_ld_rj, w_ld_co, w_smp;
   logic        r_rj_we, r_coeff_we, r_data_we;
   logic [3:0]  r_rj_waddr;
   logic [7:0]  r_rj_wdata, r_data_waddr;
   logic [8:0]  r_coeff_waddr;
   logic [15:0] r_coeff_wdata, r_data_wdata;
   logic        r_pub, r_go, r_alu_start, r_run, r_overrun, r_drop_err;

   assign bus.rj_we             = r_rj_we;
   assign bus.rj_waddr          = r_rj_waddr;
   assign bus.rj_wdata          = r_rj_wdata;
   assign bus.coeff_we          = r_coeff_we;
   assign bus.coeff_waddr       = r_coeff_waddr;
   assign bus.coeff_wdata       = r_coeff_wdata;
   assign bus.data_we           = r_data_we;
   assign bus.data_waddr        = r_data_waddr;
   assign bus.data_wdata        = r_data_wdata;
   assign bus.current_data_addr = r_cda;
   assign bus.alu_start         = r_alu_start;
   assign bus.run               = r_run;
   assign bus.sleep             = r_zcnt == LIM;
   assign bus.overrun           = r_overrun;
   assign bus.drop_err          = r_drop_err;

   // state register
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) r_state <= S_CLEAR;
      else          r_state <= w_next;
   end

   // next state: each phase ends on its last index, RUN is terminal
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_CLEAR: if (r_cnt == 9'd255) w_next = S_RJ;
         S_RJ:    if (bus.in_valid && r_cnt == 9'd15) w_next = S_COEFF;
         S_COEFF: if (bus.in_valid && r_cnt == 9'd511) w_next = S_RUN;
         default: w_next = S_RUN;
      endcase
   end

   // phase strobes and the zero-run count this word would produce
   always_comb begin
      w_clr   = r_state == S_CLEAR;
      w_ld_rj = r_state == S_RJ && bus.in_valid;
      w_ld_co = r_state == S_COEFF && bus.in_valid;
      w_smp   = r_state == S_RUN && bus.in_valid;
      w_zcnt  = bus.in_word != 16'd0 ? 10'd0 : r_zcnt == LIM ? r_zcnt : r_zcnt + 10'd1;
   end

   // phase index counter, restarted at every state change
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n)                          r_cnt <= 9'd0;
      else if (w_next != r_state)            r_cnt <= 9'd0;
      else if (w_clr || w_ld_rj || w_ld_co)  r_cnt <= r_cnt + 9'd1;
   end

   // memory write ports: one-cycle enable with registered address and data
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_rj_we       <= 1'b0;
         r_coeff_we    <= 1'b0;
         r_data_we     <= 1'b0;
         r_rj_waddr    <= 4'd0;
         r_rj_wdata    <= 8'd0;
         r_coeff_waddr <= 9'd0;
         r_coeff_wdata <= 16'd0;
         r_data_waddr  <= 8'd0;
         r_data_wdata  <= 16'd0;
      end else begin
         r_rj_we    <= w_ld_rj;
         r_coeff_we <= w_ld_co;
         r_data_we  <= w_clr || w_smp;
         if (w_ld_rj) begin
            r_rj_waddr <= r_cnt[3:0];
            r_rj_wdata <= bus.in_word[7:0];
         end
         if (w_ld_co) begin
            r_coeff_waddr <= r_cnt;
            r_coeff_wdata <= bus.in_word;
         end
         if (w_clr || w_smp) begin
            r_data_waddr <= w_clr ? r_cnt[7:0] : r_wptr;
            r_data_wdata <= w_clr ? 16'd0 : bus.in_word;
         end
      end
   end

   // sample bookkeeping: publish address and ALU start one cycle after the write lands
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_wptr      <= 8'd0;
         r_zcnt      <= 10'd0;
         r_pub       <= 1'b0;
         r_go        <= 1'b0;
         r_cda       <= 8'd0;
         r_alu_start <= 1'b0;
         r_run       <= 1'b0;
         r_overrun   <= 1'b0;
         r_drop_err  <= 1'b0;
      end else begin
         if (w_smp) begin
            r_wptr <= r_wptr + 8'd1;
            r_zcnt <= w_zcnt;
         end
         r_pub       <= w_smp;
         r_go        <= w_smp && !bus.alu_busy && w_zcnt != LIM;
         r_cda       <= r_pub ? r_data_waddr : r_cda;
         r_alu_start <= r_go;
         r_run       <= w_next == S_RUN;
         r_overrun   <= r_overrun || (w_smp && bus.alu_busy);
         r_drop_err  <= r_drop_err || (w_clr && bus.in_valid);
      end
   end
endmodule

// File: tb/tb_msdap_mem_loader.sv
// tb_msdap_mem_loader: table, directed and randomized checks of the MSDAP memory loader
module tb_msdap_mem_loader;
   typedef struct {
      logic [15:0] w;
      logic [3:0]  a;
      logic [7:0]  d;
   } rj_vec_t;

   logic clk = 1'b0;
   logic clear_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   n_start = 0;
   int   n_dwe = 0;

   // reference model: phase progress in words, circular pointer and zero run
   int   m_clr, m_nrj, m_nco, m_wp, m_zero;
   bit   m_ovr, m_drop;
   bit   p_pub, p_start;
   int   p_addr;
   bit   e_rj_we, e_co_we, e_da_we, e_start, e_run, e_sleep, e_ovr, e_drop;
   int   e_rj_a, e_rj_d, e_co_a, e_co_d, e_da_a, e_da_d, e_cda;

   msdap_mem_loader_if bus();
   msdap_mem_loader #(.ZERO_LIMIT(800)) dut (.clk(clk), .clear_n(clear_n), .bus(bus));

   always #5 clk = ~clk;

   function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %0h want %0h", n, a, e);
      end
   endfunction

   function automatic void model_reset();
      m_clr = 0; m_nrj = 0; m_nco = 0; m_wp = 0; m_zero = 0;
      m_ovr = 0; m_drop = 0; p_pub = 0; p_start = 0; p_addr = 0;
      e_rj_we = 0; e_co_we = 0; e_da_we = 0; e_start = 0; e_run = 0;
      e_sleep = 0; e_ovr = 0; e_drop = 0; e_cda = 0;
      e_rj_a = 0; e_rj_d = 0; e_co_a = 0; e_co_d = 0; e_da_a = 0; e_da_d = 0;
   endfunction

   // expected outputs after the coming rising edge, given this cycle's inputs
   function automatic void model_step(bit v, logic [15:0] w, bit b);
      e_start = p_start;
      if (p_pub) e_cda = p_addr;
      p_pub = 0; p_start = 0;
      e_rj_we = 0; e_co_we = 0; e_da_we = 0;
      if (m_clr < 256) begin
         e_da_we = 1; e_da_a = m_clr; e_da_d = 0;
         if (v) m_drop = 1;
         m_clr++;
      end else if (v && m_nrj < 16) begin
         e_rj_we = 1; e_rj_a = m_nrj; e_rj_d = int'(w[7:0]);
         m_nrj++;
      end else if (v && m_nco < 512) begin
         e_co_we = 1; e_co_a = m_nco; e_co_d = int'(w);
         m_nco++;
      end else if (v) begin
         e_da_we = 1; e_da_a = m_wp; e_da_d = int'(w);
         m_zero = (w != 0) ? 0 : (m_zero < 800 ? m_zero + 1 : 800);
         p_pub = 1; p_addr = m_wp;
         p_start = !b && m_zero != 800;
         if (b) m_ovr = 1;
         m_wp = (m_wp + 1) % 256;
      end
      e_run = m_nco == 512;
      e_sleep = m_zero == 800;
      e_ovr = m_ovr;
      e_drop = m_drop;
   endfunction

   task automatic tick(input bit v, input logic [15:0] w, input bit b);
      @(negedge clk);
      chk("rj_we", bus.rj_we, e_rj_we);
      if (e_rj_we) begin
         chk("rj_waddr", bus.rj_waddr, e_rj_a);
         chk("rj_wdata", bus.rj_wdata, e_rj_d);
      end
      chk("coeff_we", bus.coeff_we, e_co_we);
      if (e_co_we) begin
         chk("coeff_waddr", bus.coeff_waddr, e_co_a);
         chk("coeff_wdata", bus.coeff_wdata, e_co_d);
      end
      chk("data_we", bus.data_we, e_da_we);
      if (e_da_we) begin
         chk("data_waddr", bus.data_waddr, e_da_a);
         chk("data_wdata", bus.data_wdata, e_da_d);
      end
      chk("alu_start", bus.alu_start, e_start);
      chk("current_data_addr", bus.current_data_addr, e_cda);
      chk("run", bus.run, e_run);
      chk("sleep", bus.sleep, e_sleep);
      chk("overrun", bus.overrun, e_ovr);
      chk("drop_err", bus.drop_err, e_drop);
      n_start += int'(bus.alu_start);
      n_dwe += int'(bus.data_we);
      bus.in_valid = v;
      bus.in_word = w;
      bus.alu_busy = b;
      model_step(v, w, b);
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_word = 16'd0;
      bus.alu_busy = 1'b0;
      #1;
      chk("rst_we", {bus.rj_we, bus.coeff_we, bus.data_we}, 0);
      chk("rst_addr", {bus.rj_waddr, bus.coeff_waddr, bus.data_waddr, bus.current_data_addr}, 0);
      chk("rst_data", {bus.rj_wdata, bus.coeff_wdata}, 0);
      chk("rst_data_wdata", bus.data_wdata, 0);
      chk("rst_flags", {bus.alu_start, bus.run, bus.sleep, bus.overrun, bus.drop_err}, 0);
      model_reset();
      @(negedge clk);
      clear_n = 1'b1;
      n_dwe = 0;
      model_step(0, 16'd0, 0);
   endtask

   initial begin
      rj_vec_t     tv[16];
      logic [15:0] w;
      bit          v, b;
      for (int i = 0; i < 16; i++) tv[i] = '{16'h1201 + 16'(i), 4'(i), 8'h01 + 8'(i)};
      bus.in_valid = 1'b0;
      bus.in_word = 16'd0;
      bus.alu_busy = 1'b0;
      model_reset();
      do_reset();
      for (int i = 0; i < 256; i++) tick(i == 9, 16'hbeef, 0);
      chk("clear_we_count", n_dwe, 256);
      chk("clear_drop", bus.drop_err, 1);
      for (int i = 0; i < 16; i++) begin
         tick(1, tv[i].w, 0);
         tick(0, 16'd0, 0);
         chk("tbl_rj_we", bus.rj_we, 1);
         chk("tbl_rj_waddr", bus.rj_waddr, tv[i].a);
         chk("tbl_rj_wdata", bus.rj_wdata, tv[i].d);
      end
      for (int i = 0; i < 512; i++) tick(1, 16'(i), 0);
      tick(0, 16'd0, 0);
      chk("coeff_last", {bus.coeff_we, bus.coeff_waddr, bus.coeff_wdata}, {1'b1, 9'd511, 16'd511});
      chk("run_after_coeff", bus.run, 1);
      n_start = 0;
      for (int k = 1; k <= 258; k++) begin
         w = 16'($urandom_range(1, 65535));
         tick(1, w, 0);
         tick(0, 16'd0, 0);
         if (k == 256 || k == 257) chk("wrap_addr", bus.data_waddr, k == 256 ? 255 : 0);
         repeat ($urandom_range(0, 2)) tick(0, 16'd0, 0);
      end
      repeat (2) tick(0, 16'd0, 0);
      chk("wrap_starts", n_start, 258);
      n_start = 0;
      for (int k = 1; k <= 800; k++) begin
         tick(1, 16'd0, 0);
         tick(0, 16'd0, 0);
         if (k >= 799) chk("sleep_edge", bus.sleep, k == 800);
      end
      repeat (2) tick(0, 16'd0, 0);
      chk("sleep_starts", n_start, 799);
      tick(1, 16'h0005, 0);
      tick(0, 16'd0, 0);
      chk("wake_sleep", bus.sleep, 0);
      tick(0, 16'd0, 0);
      chk("wake_start", bus.alu_start, 1);
      chk("ovr_pre", bus.overrun, 0);
      tick(1, 16'h7777, 1);
      tick(0, 16'd0, 0);
      chk("ovr_write", {bus.data_we, bus.data_wdata}, {1'b1, 16'h7777});
      chk("ovr_set", bus.overrun, 1);
      tick(0, 16'd0, 0);
      chk("ovr_no_start", bus.alu_start, 0);
      repeat (3) tick(0, 16'd0, 0);
      chk("ovr_sticky", bus.overrun, 1);
      for (int i = 0; i < 900; i++) tick(1, 16'd0, $urandom_range(0, 7) == 0);
      for (int i = 0; i < 1500; i++) begin
         v = $urandom_range(0, 2) != 0;
         w = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
         b = $urandom_range(0, 4) == 0;
         tick(v, w, b);
      end
      repeat (2) tick(0, 16'd0, 0);
      do_reset();
      for (int i = 0; i < 256; i++) begin
         tick(i == 254, 16'h1234, 0);
         if (i == 254) chk("drop_pre", bus.drop_err, 0);
         if (i == 255) chk("drop_final", bus.drop_err, 1);
      end
      for (int i = 0; i < 16; i++) tick(1, 16'($urandom), 0);
      for (int i = 0; i < 100; i++) tick(1, 16'($urandom), 0);
      do_reset();
      for (int i = 0; i < 256; i++) tick(0, 16'd0, 0);
      tick(1, 16'h12ab, 0);
      tick(0, 16'd0, 0);
      chk("reload_rj0", {bus.rj_we, bus.rj_waddr, bus.rj_wdata}, {1'b1, 4'd0, 8'hab});
      tick(1, 16'h12cd, 0);
      tick(0, 16'd0, 0);
      chk("reload_rj1", {bus.rj_we, bus.rj_waddr, bus.rj_wdata}, {1'b1, 4'd1, 8'hcd});
      repeat (2) tick(0, 16'd0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
